rgb_breath_pwm: RTL

//   Parametrised multi-channel breathing-LED PWM engine; successor of the single-channel breather.

---
 rtl/rgb_breath_pwm_if.sv | 29 ++
 rtl/rgb_breath_pwm.sv | 95 +++++++++
 2 files changed

// File: rtl/rgb_breath_pwm_if.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_breath_pwm_if
//  Brief    : Control/status bundle for the multi-channel breathing PWM engine.
//  Revision : 1.0
// ============================================================================
interface rgb_breath_pwm_if #(
    parameter int NCH = 3
);
    logic               en;
    logic [2*NCH-1:0]   mode;
    logic [NCH-1:0]     led;
    logic               frame_tick;

    modport master (
        output en,
        output mode,
        input  led,
        input  frame_tick
    );

    modport slave (
        input  en,
        input  mode,
        output led,
        output frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/rgb_breath_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_breath_pwm
//  Brief    : NCH-channel breathing/blink LED PWM with shared prescaler and frame counter.
//  Revision : 1.0
// ============================================================================
module rgb_breath_pwm #(
    parameter int PRESCALE   = 100,
    parameter int STEPS      = 1000,
    parameter int NCH        = 3,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    rgb_breath_pwm_if.slave     bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [PW-1:0]  C_PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0]  C_STEP_LAST = SW'(STEPS - 1);
    localparam logic [NCH-1:0] C_DARK      = {NCH{ACTIVE_LOW}};

    logic [PW-1:0]      r_pre_cnt;
    logic [SW-1:0]      r_pwm_cnt;
    logic [SW-1:0]      r_duty [NCH];
    logic [NCH-1:0]     r_dir_down;
    logic [2*NCH-1:0]   r_mode_q;
    logic [NCH-1:0]     r_led;
    logic               r_frame_tick;

    logic               w_step_tick;
    logic               w_frame_end;
    logic [NCH-1:0]     w_lit;

    assign w_step_tick = bus.en & (r_pre_cnt == C_PRE_LAST);
    assign w_frame_end = w_step_tick & (r_pwm_cnt == C_STEP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else if (bus.en) begin
            r_pre_cnt <= (r_pre_cnt == C_PRE_LAST) ? '0 : r_pre_cnt + PW'(1);
            if (w_step_tick)
                r_pwm_cnt <= (r_pwm_cnt == C_STEP_LAST) ? '0 : r_pwm_cnt + SW'(1);
        end
    end

    // Triangular ramp: the turn-around frame holds duty, so peak/trough span two frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q   <= '0;
            r_dir_down <= '0;
            for (int i = 0; i < NCH; i++)
                r_duty[i] <= SW'((i * STEPS) / NCH);
        end else if (w_frame_end) begin
            r_mode_q <= bus.mode;
            for (int i = 0; i < NCH; i++) begin
                if (!r_dir_down[i]) begin
                    if (r_duty[i] == C_STEP_LAST)
                        r_dir_down[i] <= 1'b1;
                    else
                        r_duty[i] <= r_duty[i] + SW'(1);
                end else begin
                    if (r_duty[i] == '0)
                        r_dir_down[i] <= 1'b0;
                    else
                        r_duty[i] <= r_duty[i] - SW'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [1:0] w_m;
        assign w_m      = r_mode_q[2*i+1:2*i];
        assign w_lit[i] = (w_m == 2'b01)
                        | ((w_m == 2'b10) & (r_pwm_cnt < r_duty[i]))
                        | ((w_m == 2'b11) & ~r_dir_down[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led        <= C_DARK;
            r_frame_tick <= 1'b0;
        end else begin
            r_led        <= bus.en ? (w_lit ^ C_DARK) : C_DARK;
            r_frame_tick <= w_frame_end;
        end
    end

    assign bus.led        = r_led;
    assign bus.frame_tick = r_frame_tick;
endmodule
`default_nettype wire
